// File: rtl/actor_trigger_pkg.sv
// Shared trigger encodings: actor return codes, trigger FSM states and trigger modes.
package TriggerTypes;

  typedef enum logic [31:0] {
    IDLE           = 32'd0,
    WAIT_PREDICATE = 32'd1,
    WAIT_INPUT     = 32'd2,
    WAIT_OUTPUT    = 32'd3,
    WAIT_GAURD     = 32'd4,
    EXECUTED       = 32'd5
  } return_t;

  typedef enum logic [2:0] {
    IDLE_STATE,
    LAUNCH,
    CHECK,
    SLEEP,
    SYNC_LAUNCH,
    SYNC_CHECK,
    SYNC_WAIT,
    SYNC_EXEC
  } state_t;

  typedef enum logic [1:0] {
    ACTOR_TRIGGER,
    INPUT_TRIGGER,
    OUTPUT_TRIGGER
  } mode_t;

endpackage

// File: rtl/actor_trigger_if.sv
// ap_ctrl_hs handshake between a trigger (master) and its HLS actor (slave).
interface actor_trigger_if;
  import TriggerTypes::*;

  logic        actor_start;
  logic        actor_ready;
  logic        actor_done;
  logic [31:0] actor_return;

  modport master (
    output actor_start,
    input  actor_ready,
    input  actor_done,
    input  actor_return
  );

  modport slave (
    input  actor_start,
    output actor_ready,
    output actor_done,
    output actor_return
  );

endinterface

// File: rtl/actor_trigger_sleep_timer.sv
// Loadable down-counter timing how long an idle actor stays asleep; saturates at zero.
module trigger_sleep_timer #(
  parameter int SLEEP_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = (SLEEP_CYCLES > 0) ? $clog2(SLEEP_CYCLES + 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(SLEEP_CYCLES);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/actor_trigger.sv
// Per-actor scheduling controller: launches an ap_ctrl_hs actor, decodes its return code,
// sleeps it when idle and joins the network-wide sync protocol for global termination.
module actor_trigger
  import TriggerTypes::*;
#(
  parameter mode_t MODE         = ACTOR_TRIGGER,
  parameter int    SLEEP_CYCLES = 16
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   ap_start,
  output logic                   ap_idle,
  output logic                   ap_done,
  actor_trigger_if.master        act,
  input  logic                   external_enqueue,
  input  logic                   all_sleep,
  input  logic                   all_sync_wait,
  input  logic                   all_sync_exec,
  output logic                   sleep,
  output logic                   sync_wait,
  output logic                   sync_exec
);

  state_t      state;
  state_t      state_nxt;
  logic        launched;
  logic [31:0] ret_q;
  logic        ap_done_q;
  logic        actor_start_c;
  logic        timer_load;
  logic        timer_en;
  logic        timer_expired;
  logic        in_launch;
  logic        ret_fast_sync;

  assign in_launch = (state == LAUNCH) || (state == SYNC_LAUNCH);

  // A mode-matched blocking code means the actor can only wait on the network, so skip SLEEP.
  assign ret_fast_sync = ((MODE == INPUT_TRIGGER)  && (ret_q == WAIT_INPUT)) ||
                         ((MODE == OUTPUT_TRIGGER) && (ret_q == WAIT_OUTPUT));

  trigger_sleep_timer #(
    .SLEEP_CYCLES(SLEEP_CYCLES)
  ) u_timer (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .load    (timer_load),
    .en      (timer_en),
    .expired (timer_expired)
  );

  assign timer_load = (state == CHECK) && (state_nxt == SLEEP);
  assign timer_en   = (state == SLEEP) && !external_enqueue;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE_STATE: begin
        if (ap_start) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        if (act.actor_done) state_nxt = CHECK;
      end
      SYNC_LAUNCH: begin
        if (act.actor_done) state_nxt = SYNC_CHECK;
      end
      CHECK: begin
        if (ret_q == EXECUTED)  state_nxt = LAUNCH;
        else if (ret_fast_sync) state_nxt = SYNC_LAUNCH;
        else                    state_nxt = SLEEP;
      end
      SLEEP: begin
        if (external_enqueue)   state_nxt = LAUNCH;
        else if (timer_expired) state_nxt = all_sleep ? SYNC_LAUNCH : LAUNCH;
      end
      SYNC_CHECK: begin
        state_nxt = (ret_q == EXECUTED) ? LAUNCH : SYNC_WAIT;
      end
      SYNC_WAIT: begin
        if (all_sync_wait)   state_nxt = SYNC_EXEC;
        else if (!all_sleep) state_nxt = LAUNCH;
      end
      SYNC_EXEC: begin
        if (all_sync_exec)   state_nxt = IDLE_STATE;
        else if (!all_sleep) state_nxt = LAUNCH;
      end
      default: state_nxt = IDLE_STATE;
    endcase
  end

  // Handshake bookkeeping: launched masks actor_start once the actor has accepted.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      launched  <= 1'b0;
      ret_q     <= IDLE;
      ap_done_q <= 1'b0;
    end else begin
      ap_done_q <= (state == SYNC_EXEC) && all_sync_exec;
      if (in_launch) begin
        if (act.actor_done) begin
          launched <= 1'b0;
          ret_q    <= act.actor_return;
        end else if (act.actor_ready) begin
          launched <= 1'b1;
        end
      end else begin
        launched <= 1'b0;
      end
    end
  end

  always_comb begin
    ap_idle       = 1'b0;
    sleep         = 1'b0;
    sync_wait     = 1'b0;
    sync_exec     = 1'b0;
    actor_start_c = 1'b0;
    case (state)
      IDLE_STATE:  ap_idle = 1'b1;
      LAUNCH:      actor_start_c = !launched;
      SLEEP:       sleep = 1'b1;
      SYNC_LAUNCH: begin
        sleep         = 1'b1;
        actor_start_c = !launched;
      end
      SYNC_CHECK:  sleep = 1'b1;
      SYNC_WAIT: begin
        sleep     = 1'b1;
        sync_wait = 1'b1;
      end
      SYNC_EXEC: begin
        sleep     = 1'b1;
        sync_wait = 1'b1;
        sync_exec = 1'b1;
      end
      default: ;
    endcase
  end

  assign act.actor_start = actor_start_c;
  assign ap_done         = ap_done_q;

endmodule

// File: tb/tb_actor_trigger.sv
// Directed bench for actor_trigger: firing cadence, sleep timing, wake, sync protocol, reset.
module tb_actor_trigger;
  import TriggerTypes::*;

  logic ap_clk;
  logic ap_rst_n;

  // ACTOR_TRIGGER instance
  logic ap_start_a, ap_idle_a, ap_done_a;
  logic ext_a, sleep_a, sync_wait_a, sync_exec_a;
  logic all_sleep_r, all_sync_wait_r, all_sync_exec_r, loopback;
  logic all_sleep_a, all_sync_wait_a, all_sync_exec_a;
  actor_trigger_if if_a ();

  // INPUT_TRIGGER instance
  logic ap_start_i, ap_idle_i, ap_done_i;
  logic ext_i, sleep_i, sync_wait_i, sync_exec_i;
  logic all_sleep_i, all_sync_wait_i, all_sync_exec_i;
  actor_trigger_if if_i ();

  int compared   = 0;
  int mismatched = 0;
  int n;

  assign all_sleep_a     = loopback ? sleep_a     : all_sleep_r;
  assign all_sync_wait_a = loopback ? sync_wait_a : all_sync_wait_r;
  assign all_sync_exec_a = loopback ? sync_exec_a : all_sync_exec_r;

  actor_trigger #(.MODE(ACTOR_TRIGGER), .SLEEP_CYCLES(16)) dut_a (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start_a),
    .ap_idle(ap_idle_a), .ap_done(ap_done_a), .act(if_a.master),
    .external_enqueue(ext_a), .all_sleep(all_sleep_a),
    .all_sync_wait(all_sync_wait_a), .all_sync_exec(all_sync_exec_a),
    .sleep(sleep_a), .sync_wait(sync_wait_a), .sync_exec(sync_exec_a)
  );

  actor_trigger #(.MODE(INPUT_TRIGGER), .SLEEP_CYCLES(16)) dut_i (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start_i),
    .ap_idle(ap_idle_i), .ap_done(ap_done_i), .act(if_i.master),
    .external_enqueue(ext_i), .all_sleep(all_sleep_i),
    .all_sync_wait(all_sync_wait_i), .all_sync_exec(all_sync_exec_i),
    .sleep(sleep_i), .sync_wait(sync_wait_i), .sync_exec(sync_exec_i)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  // One ready+done handshake on dut_a from LAUNCH/SYNC_LAUNCH; leaves it in CHECK/SYNC_CHECK.
  task automatic fire_a(input logic [31:0] r);
    check("fire_start", {31'd0, if_a.actor_start}, 32'd1);
    if_a.actor_ready  = 1'b1;
    if_a.actor_done   = 1'b1;
    if_a.actor_return = r;
    step();
    if_a.actor_ready = 1'b0;
    if_a.actor_done  = 1'b0;
    check("fire_ack", {31'd0, if_a.actor_start}, 32'd0);
  endtask

  // Counts cycles spent in SLEEP (sleep high, no actor_start), bounded.
  task automatic wait_sleep(output int cnt);
    cnt = 0;
    while (sleep_a && !if_a.actor_start && cnt < 40) begin
      cnt++;
      step();
    end
  endtask

  initial begin
    ap_rst_n = 1'b0;
    ap_start_a = 1'b0; ext_a = 1'b0;
    all_sleep_r = 1'b0; all_sync_wait_r = 1'b0; all_sync_exec_r = 1'b0; loopback = 1'b0;
    if_a.actor_ready = 1'b0; if_a.actor_done = 1'b0; if_a.actor_return = 32'd0;
    ap_start_i = 1'b0; ext_i = 1'b0;
    all_sleep_i = 1'b0; all_sync_wait_i = 1'b0; all_sync_exec_i = 1'b0;
    if_i.actor_ready = 1'b0; if_i.actor_done = 1'b0; if_i.actor_return = 32'd0;
    #1;
    check("rst_idle",   {31'd0, ap_idle_a}, 32'd1);
    check("rst_start",  {31'd0, if_a.actor_start}, 32'd0);
    check("rst_done",   {31'd0, ap_done_a}, 32'd0);
    check("rst_sleep",  {31'd0, sleep_a}, 32'd0);
    check("rst_swait",  {31'd0, sync_wait_a}, 32'd0);
    check("rst_sexec",  {31'd0, sync_exec_a}, 32'd0);
    step(); step();
    ap_rst_n = 1'b1;
    step();
    check("idle_hold", {31'd0, ap_idle_a}, 32'd1);

    // Start, three EXECUTED firings at a 2-cycle period, then WAIT_INPUT -> SLEEP
    ap_start_a = 1'b1;
    step();
    ap_start_a = 1'b0;
    check("launch_idle", {31'd0, ap_idle_a}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      fire_a(EXECUTED);
      step();
    end
    fire_a(WAIT_INPUT);
    step();
    check("sleep_enter", {31'd0, sleep_a}, 32'd1);
    check("sleep_nostart", {31'd0, if_a.actor_start}, 32'd0);
    wait_sleep(n);
    check("sleep_len", n, 32'd17);
    check("relaunch_start", {31'd0, if_a.actor_start}, 32'd1);
    check("relaunch_sleep", {31'd0, sleep_a}, 32'd0);

    // Wake from SLEEP with external_enqueue at counter 8
    fire_a(WAIT_GAURD);
    step();
    repeat (8) step();
    check("wake_presleep", {31'd0, sleep_a}, 32'd1);
    ext_a = 1'b1;
    step();
    ext_a = 1'b0;
    check("wake_start", {31'd0, if_a.actor_start}, 32'd1);
    check("wake_sleep", {31'd0, sleep_a}, 32'd0);

    // Ready before done: actor_start drops after ready, handshake completes later
    if_a.actor_ready = 1'b1;
    step();
    if_a.actor_ready = 1'b0;
    check("split_ready", {31'd0, if_a.actor_start}, 32'd0);
    step();
    check("split_hold", {31'd0, if_a.actor_start}, 32'd0);
    if_a.actor_done = 1'b1;
    if_a.actor_return = EXECUTED;
    step();
    if_a.actor_done = 1'b0;
    step();
    check("split_relaunch", {31'd0, if_a.actor_start}, 32'd1);

    // SYNC_WAIT abandoned when a peer wakes
    all_sleep_r = 1'b1;
    fire_a(WAIT_GAURD);
    step();
    wait_sleep(n);
    check("sync_sleep_len", n, 32'd17);
    check("slaunch_start", {31'd0, if_a.actor_start}, 32'd1);
    check("slaunch_sleep", {31'd0, sleep_a}, 32'd1);
    fire_a(WAIT_GAURD);
    check("scheck_sleep", {31'd0, sleep_a}, 32'd1);
    check("scheck_swait", {31'd0, sync_wait_a}, 32'd0);
    step();
    check("swait_swait", {31'd0, sync_wait_a}, 32'd1);
    check("swait_sexec", {31'd0, sync_exec_a}, 32'd0);
    all_sleep_r = 1'b0;
    step();
    check("abort_swait", {31'd0, sync_wait_a}, 32'd0);
    check("abort_sleep", {31'd0, sleep_a}, 32'd0);
    check("abort_start", {31'd0, if_a.actor_start}, 32'd1);

    // Single-actor network: termination through the full sync path
    loopback = 1'b1;
    fire_a(WAIT_GAURD);
    step();
    wait_sleep(n);
    check("term_sleep_len", n, 32'd17);
    check("term_slaunch", {31'd0, if_a.actor_start}, 32'd1);
    fire_a(WAIT_GAURD);
    step();
    check("term_swait", {31'd0, sync_wait_a}, 32'd1);
    check("term_swait_done", {31'd0, ap_done_a}, 32'd0);
    step();
    check("term_sexec", {31'd0, sync_exec_a}, 32'd1);
    check("term_sexec_done", {31'd0, ap_done_a}, 32'd0);
    step();
    check("term_done", {31'd0, ap_done_a}, 32'd1);
    check("term_idle", {31'd0, ap_idle_a}, 32'd1);
    check("term_sleep", {31'd0, sleep_a}, 32'd0);
    step();
    check("term_done_pulse", {31'd0, ap_done_a}, 32'd0);
    check("term_idle_hold", {31'd0, ap_idle_a}, 32'd1);
    loopback = 1'b0;

    // INPUT_TRIGGER: WAIT_INPUT goes straight to SYNC_LAUNCH; code 7 sleeps
    ap_start_i = 1'b1;
    step();
    ap_start_i = 1'b0;
    check("in_launch", {31'd0, if_i.actor_start}, 32'd1);
    if_i.actor_ready = 1'b1; if_i.actor_done = 1'b1; if_i.actor_return = WAIT_INPUT;
    step();
    if_i.actor_ready = 1'b0; if_i.actor_done = 1'b0;
    check("in_check_sleep", {31'd0, sleep_i}, 32'd0);
    step();
    check("in_slaunch_start", {31'd0, if_i.actor_start}, 32'd1);
    check("in_slaunch_sleep", {31'd0, sleep_i}, 32'd1);
    if_i.actor_ready = 1'b1; if_i.actor_done = 1'b1; if_i.actor_return = 32'd7;
    step();
    if_i.actor_ready = 1'b0; if_i.actor_done = 1'b0;
    check("in_scheck_start", {31'd0, if_i.actor_start}, 32'd0);
    step();
    check("in_swait", {31'd0, sync_wait_i}, 32'd1);
    step();
    check("in_abort_start", {31'd0, if_i.actor_start}, 32'd1);
    check("in_abort_sleep", {31'd0, sleep_i}, 32'd0);
    if_i.actor_ready = 1'b1; if_i.actor_done = 1'b1; if_i.actor_return = 32'd7;
    step();
    if_i.actor_ready = 1'b0; if_i.actor_done = 1'b0;
    step();
    check("in_code7_sleep", {31'd0, sleep_i}, 32'd1);
    check("in_code7_start", {31'd0, if_i.actor_start}, 32'd0);
    check("in_code7_swait", {31'd0, sync_wait_i}, 32'd0);

    // Asynchronous reset while actor_start is high
    ap_start_a = 1'b1;
    step();
    ap_start_a = 1'b0;
    check("arst_pre_start", {31'd0, if_a.actor_start}, 32'd1);
    #2 ap_rst_n = 1'b0;
    #1;
    check("arst_start", {31'd0, if_a.actor_start}, 32'd0);
    check("arst_idle",  {31'd0, ap_idle_a}, 32'd1);
    check("arst_done",  {31'd0, ap_done_a}, 32'd0);
    check("arst_sleep", {31'd0, sleep_a}, 32'd0);
    check("arst_i_sleep", {31'd0, sleep_i}, 32'd0);
    step();
    check("arst_hold_done", {31'd0, ap_done_a}, 32'd0);
    ap_rst_n = 1'b1;
    step();
    check("arst_rel_idle",  {31'd0, ap_idle_a}, 32'd1);
    check("arst_rel_start", {31'd0, if_a.actor_start}, 32'd0);
    check("arst_rel_done",  {31'd0, ap_done_a}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
